bus_register_arbiter: RTL

Shares the common 8-bit data bus and a bank of octal 3-state registers (clock-enable, output-enable, clear; all active-low) between several requesters. It grants one requester at a time using round-robin priority. For each transaction it drives the strobes of the selected register in a fixed sequence. It sits between the datapath's bus masters and the register bank, so no two registers ever drive the bus together and no write coincides with a read.

---
 rtl/bus_register_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bus_register_arbiter.sv
// +------------------------------------------------------------------------+
// | bus_register_arbiter: round-robin bus arbiter sequencing the strobes   |
// | of a bank of 3-state registers.                          Revision 1.0  |
// +------------------------------------------------------------------------+
`default_nettype none

module bus_register_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_REG = 4,
  parameter int SEL_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [2*NUM_REQ-1:0]     op,
  input  logic [SEL_W*NUM_REQ-1:0] sel,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic [NUM_REG-1:0]       reg_clken_n,
  output logic [NUM_REG-1:0]       reg_oe_n,
  output logic [NUM_REG-1:0]       reg_clr_n,
  output logic                     busy
);

  localparam int WIN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ1 = 3'd2,
    READ2 = 3'd3,
    CLEAR = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t             r_state;
  logic [WIN_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   r_sel;

  logic               w_found;
  logic [WIN_W-1:0]   w_win;
  logic [WIN_W-1:0]   w_next_ptr;
  logic [1:0]         w_op;
  logic [SEL_W-1:0]   w_sel;
  logic               w_reject;
  int                 w_idx;

  // Search starts at the pointer, so the previous winner is checked last.
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_next_ptr = '0;
    w_op       = '0;
    w_sel      = '0;
    w_idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        w_win      = WIN_W'(w_idx);
        w_next_ptr = WIN_W'((w_idx + 1) % NUM_REQ);
        w_op       = op[2*w_idx +: 2];
        w_sel      = sel[SEL_W*w_idx +: SEL_W];
      end
    end
  end

  assign w_reject = (w_op == 2'b11) || (int'(w_sel) >= NUM_REG);

  function automatic logic [NUM_REG-1:0] strobe_n(input logic [SEL_W-1:0] s);
    logic [NUM_REG-1:0] v;
    for (int j = 0; j < NUM_REG; j++) begin
      v[j] = (int'(s) != j);
    end
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_sel       <= '0;
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      reg_clken_n <= '1;
      reg_oe_n    <= '1;
      reg_clr_n   <= '1;
      busy        <= 1'b0;
    end else begin
      done        <= '0;
      err         <= 1'b0;
      reg_clken_n <= '1;
      reg_oe_n    <= '1;
      reg_clr_n   <= '1;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_ptr <= w_next_ptr;
            r_sel <= w_sel;
            gnt   <= NUM_REQ'(1) << w_win;
            busy  <= 1'b1;
            if (w_reject) begin
              r_state <= DONE;
              done    <= NUM_REQ'(1) << w_win;
              err     <= 1'b1;
            end else begin
              case (w_op)
                2'b00: begin
                  r_state     <= WRITE;
                  reg_clken_n <= strobe_n(w_sel);
                end
                2'b01: begin
                  r_state  <= READ1;
                  reg_oe_n <= strobe_n(w_sel);
                end
                default: begin
                  r_state   <= CLEAR;
                  reg_clr_n <= strobe_n(w_sel);
                end
              endcase
            end
          end
        end
        READ1: begin
          r_state  <= READ2;
          reg_oe_n <= strobe_n(r_sel);
        end
        WRITE, READ2, CLEAR: begin
          r_state <= DONE;
          done    <= gnt;
        end
        DONE: begin
          r_state <= IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
